// File: rtl/spi_pkg.sv
// Shared SPI controller definitions: register offsets, bus widths and the
// sampled 6502 bus record used by the bus front end.
package spi_pkg;

  localparam int unsigned SPI_REG_W  = 4;
  localparam int unsigned SPI_DATA_W = 8;

  localparam logic [SPI_REG_W-1:0] SPI_REG_CS   = 4'h0;
  localparam logic [SPI_REG_W-1:0] SPI_REG_DATA = 4'h1;

  typedef enum logic {
    WR_EMPTY = 1'b0,
    WR_FULL  = 1'b1
  } wr_state_e;

  typedef struct packed {
    logic                  cs;
    logic                  rw;
    logic [SPI_REG_W-1:0]  addr;
    logic [SPI_DATA_W-1:0] data;
  } bus_sample_t;

endpackage

// File: rtl/sync_bus.sv
// Multi-bit flop-chain synchroniser; every bit sees the same delay so a
// bundled bus stays coherent relative to its sampled clock bit.
module sync_bus #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else begin
      stage <= {stage[STAGES-2:0], d};
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/spi_bus_if.sv
// 6502 bus front end for the SPI controller: samples PHI2 and the bus in the
// SPI clock domain, commits writes as valid/ready transactions, serves reads.
module spi_bus_if
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clock_spi,
  input  logic                  reset_b,
  input  logic                  clock_sys,
  input  logic                  cs,
  input  logic [7:0]            addr,
  input  logic [SPI_DATA_W-1:0] data_in,
  input  logic                  rw,
  output logic [SPI_DATA_W-1:0] data_out,
  output logic                  data_out_en,
  output logic [SPI_REG_W-1:0]  rd_addr,
  input  logic [SPI_DATA_W-1:0] rd_data,
  output logic                  rd_strobe,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [SPI_REG_W-1:0]  wr_addr,
  output logic [SPI_DATA_W-1:0] wr_data,
  output logic                  overrun,
  input  logic                  overrun_clr
);

  localparam int unsigned BUS_W = 1 + $bits(bus_sample_t);

  logic [BUS_W-1:0] bus_raw;
  logic [BUS_W-1:0] bus_s;
  bus_sample_t      bus_now;
  bus_sample_t      smp;
  logic             phi2_s;
  logic             phi2_q;
  logic             armed;
  logic [SYNC_STAGES:0] fill;
  logic             sync_ok;
  logic             rise;
  logic             fall;
  logic             commit_wr;
  logic             commit_rd;
  logic             rd_cond;
  wr_state_e        state_q;
  wr_state_e        state_d;
  logic             load;
  logic             ovr_set;
  logic             unused_addr;

  assign unused_addr = ^addr[7:SPI_REG_W];
  assign bus_raw     = {clock_sys, cs, rw, addr[SPI_REG_W-1:0], data_in};

  sync_bus #(
    .WIDTH  (BUS_W),
    .STAGES (SYNC_STAGES)
  ) u_sync_bus (
    .clk   (clock_spi),
    .rst_n (reset_b),
    .d     (bus_raw),
    .q     (bus_s)
  );

  assign phi2_s  = bus_s[BUS_W-1];
  assign bus_now = bus_s[BUS_W-2:0];
  assign rd_addr = bus_now.addr;

  // Edges only count once the sync chain and phi2_q hold real bus history,
  // so a reset release during PHI2 high does not look like a rise.
  assign sync_ok   = fill[SYNC_STAGES];
  assign rise      = phi2_s & ~phi2_q & sync_ok;
  assign fall      = ~phi2_s & phi2_q & armed;
  assign commit_wr = fall & ~smp.cs & ~smp.rw;
  assign commit_rd = fall & ~smp.cs & smp.rw;
  assign rd_cond   = phi2_s & ~bus_now.cs & bus_now.rw;

  // Edge detection, arming and the last-seen-while-high bus sample.
  always_ff @(posedge clock_spi or negedge reset_b) begin
    if (!reset_b) begin
      fill   <= '0;
      phi2_q <= 1'b0;
      armed  <= 1'b0;
      smp    <= '0;
    end else begin
      fill   <= {fill[SYNC_STAGES-1:0], 1'b1};
      phi2_q <= phi2_s;
      if (rise) armed <= 1'b1;
      if (phi2_s) smp <= bus_now;
    end
  end

  // Write holding register next state.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    ovr_set = 1'b0;
    case (state_q)
      WR_EMPTY: begin
        if (commit_wr) begin
          state_d = WR_FULL;
          load    = 1'b1;
        end
      end
      WR_FULL: begin
        if (wr_ready) begin
          if (commit_wr) load = 1'b1;
          else           state_d = WR_EMPTY;
        end else if (commit_wr) begin
          ovr_set = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock_spi or negedge reset_b) begin
    if (!reset_b) begin
      state_q   <= WR_EMPTY;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      overrun   <= 1'b0;
      rd_strobe <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_valid  <= (state_d == WR_FULL);
      rd_strobe <= commit_rd;
      if (load) begin
        wr_addr <= smp.addr;
        wr_data <= smp.data;
      end
      if (ovr_set)          overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

  // Read data path toward the bus.
  always_ff @(posedge clock_spi or negedge reset_b) begin
    if (!reset_b) begin
      data_out_en <= 1'b0;
      data_out    <= '0;
    end else begin
      data_out_en <= rd_cond;
      if (rd_cond) data_out <= rd_data;
    end
  end

endmodule

// File: tb/tb_spi_bus_if.sv
// Directed bench for spi_bus_if: a vector table of single bus cycles plus
// hand-written sequences for stall, overrun, swap and reset corner cases.
module tb_spi_bus_if;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       reset_b;
  logic       clock_sys;
  logic       cs;
  logic [7:0] addr;
  logic [7:0] data_in;
  logic       rw;
  logic [7:0] data_out;
  logic       data_out_en;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_strobe;
  logic       wr_valid;
  logic       wr_ready;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       overrun;
  logic       overrun_clr;

  always #5 clk = ~clk;

  spi_bus_if #(.SYNC_STAGES(2)) dut (
    .clock_spi   (clk),
    .reset_b     (reset_b),
    .clock_sys   (clock_sys),
    .cs          (cs),
    .addr        (addr),
    .data_in     (data_in),
    .rw          (rw),
    .data_out    (data_out),
    .data_out_en (data_out_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_strobe   (rd_strobe),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int acc_cnt, rd_cnt, en_cnt, first_wr, first_rd, en_first, en_last;
  logic [7:0]  en_data;
  logic [3:0]  en_rd_addr;
  logic [11:0] acc_q[$];

  typedef struct {
    logic       c;
    logic       r;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] rdd;
    int         exp_acc;
    int         exp_rd;
    logic [3:0] exp_waddr;
    logic [7:0] exp_wdata;
    logic       exp_en;
    logic [7:0] exp_dout;
    logic [3:0] exp_raddr;
  } vec_t;

  vec_t vt[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_mon();
    acc_cnt  = 0;
    rd_cnt   = 0;
    en_cnt   = 0;
    first_wr = -1;
    first_rd = -1;
    en_first = -1;
    en_last  = -1;
    acc_q.delete();
  endtask

  // Handshake is recorded before the edge that consumes it; outputs after it.
  task automatic tick();
    if (wr_valid && wr_ready) begin
      acc_cnt++;
      acc_q.push_back({wr_addr, wr_data});
    end
    @(posedge clk);
    #1;
    cyc++;
    if (wr_valid && first_wr < 0) first_wr = cyc;
    if (rd_strobe) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (data_out_en) begin
      en_cnt++;
      if (en_first < 0) en_first = cyc;
      en_last    = cyc;
      en_data    = data_out;
      en_rd_addr = rd_addr;
    end
  endtask

  // One 6502 cycle at 8:1: four SPI clocks low, four high, then idle.
  task automatic bus_cycle(input logic c, input logic r, input logic [7:0] a,
                           input logic [7:0] d, input int ready_at);
    clock_sys = 1'b0;
    cs = c; rw = r; addr = a; data_in = d;
    repeat (4) tick();
    clock_sys = 1'b1;
    repeat (4) tick();
    clock_sys = 1'b0;
    cs = 1'b1; rw = 1'b1;
    fall_cyc = cyc;
    for (int i = 0; i < 8; i++) begin
      if (i == ready_at) wr_ready = 1'b1;
      else if (ready_at >= 0 && i == ready_at + 1) wr_ready = 1'b0;
      tick();
    end
  endtask

  initial begin
    vt[0] = '{1'b0, 1'b1, 8'h10, 8'h00, 8'hFF, 0, 1, 4'h0, 8'h00, 1'b1, 8'hFF, SPI_REG_CS};
    vt[1] = '{1'b0, 1'b0, 8'h10, 8'hFE, 8'h00, 1, 0, 4'h0, 8'hFE, 1'b0, 8'h00, 4'h0};
    vt[2] = '{1'b0, 1'b0, 8'h13, 8'h5A, 8'h00, 1, 0, 4'h3, 8'h5A, 1'b0, 8'h00, 4'h0};
    vt[3] = '{1'b1, 1'b0, 8'h11, 8'h99, 8'h00, 0, 0, 4'h0, 8'h00, 1'b0, 8'h00, 4'h0};
    vt[4] = '{1'b1, 1'b1, 8'h12, 8'h00, 8'h77, 0, 0, 4'h0, 8'h00, 1'b0, 8'h00, 4'h0};
    vt[5] = '{1'b0, 1'b1, 8'h2F, 8'h00, 8'h3C, 0, 1, 4'h0, 8'h00, 1'b1, 8'h3C, 4'hF};

    reset_b = 1'b0; clock_sys = 1'b0; cs = 1'b1; rw = 1'b1;
    addr = 8'h00; data_in = 8'h00; rd_data = 8'h00;
    wr_ready = 1'b1; overrun_clr = 1'b0;
    clear_mon();
    repeat (3) tick();
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_out_en", 32'(data_out_en), 32'h0);
    check("rst_rd_strobe", 32'(rd_strobe), 32'h0);
    check("rst_wr_valid", 32'(wr_valid), 32'h0);
    check("rst_wr_addr", 32'(wr_addr), 32'h0);
    check("rst_wr_data", 32'(wr_data), 32'h00);
    check("rst_overrun", 32'(overrun), 32'h0);
    reset_b = 1'b1;
    repeat (4) tick();

    for (int i = 0; i < 6; i++) begin
      clear_mon();
      rd_data = vt[i].rdd;
      bus_cycle(vt[i].c, vt[i].r, vt[i].a, vt[i].d, -1);
      check($sformatf("v%0d_accepts", i), 32'(acc_cnt), 32'(vt[i].exp_acc));
      check($sformatf("v%0d_rd_strobes", i), 32'(rd_cnt), 32'(vt[i].exp_rd));
      check($sformatf("v%0d_out_en_seen", i), 32'(en_cnt > 0), 32'(vt[i].exp_en));
      check($sformatf("v%0d_wr_valid_idle", i), 32'(wr_valid), 32'h0);
      if (vt[i].exp_acc > 0) begin
        check($sformatf("v%0d_wr_payload", i), 32'(acc_q[0]), 32'({vt[i].exp_waddr, vt[i].exp_wdata}));
        check($sformatf("v%0d_wr_latency", i), 32'(first_wr), 32'(fall_cyc + 3));
      end
      if (vt[i].exp_rd > 0)
        check($sformatf("v%0d_rd_latency", i), 32'(first_rd), 32'(fall_cyc + 3));
      if (vt[i].exp_en) begin
        check($sformatf("v%0d_data_out", i), 32'(en_data), 32'(vt[i].exp_dout));
        check($sformatf("v%0d_rd_addr", i), 32'(en_rd_addr), 32'(vt[i].exp_raddr));
        check($sformatf("v%0d_en_last", i), 32'(en_last), 32'(fall_cyc + 2));
        check($sformatf("v%0d_en_before_fall", i), 32'(en_first <= fall_cyc - 1), 32'h1);
      end
    end

    // Stalled write holds its payload until accepted.
    clear_mon();
    wr_ready = 1'b0;
    bus_cycle(1'b0, 1'b0, 8'h11, 8'hDB, -1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_hold%0d", i), 32'({wr_valid, wr_addr, wr_data}), 32'({1'b1, SPI_REG_DATA, 8'hDB}));
      tick();
    end
    wr_ready = 1'b1;
    tick();
    check("stall_valid_drop", 32'(wr_valid), 32'h0);
    tick();
    check("stall_accepts", 32'(acc_cnt), 32'h1);
    check("stall_payload", 32'(acc_q[0]), 32'({4'h1, 8'hDB}));

    // Overrun: second write dropped, flag sticky until cleared.
    clear_mon();
    wr_ready = 1'b0;
    bus_cycle(1'b0, 1'b0, 8'h12, 8'h11, -1);
    bus_cycle(1'b0, 1'b0, 8'h13, 8'h22, -1);
    check("ovr_kept_data", 32'({wr_valid, wr_addr, wr_data}), 32'({1'b1, 4'h2, 8'h11}));
    check("ovr_set", 32'(overrun), 32'h1);
    repeat (3) tick();
    check("ovr_sticky", 32'(overrun), 32'h1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'h0);
    wr_ready = 1'b1;
    repeat (2) tick();
    check("ovr_accepts", 32'(acc_cnt), 32'h1);
    check("ovr_payload", 32'(acc_q[0]), 32'({4'h2, 8'h11}));

    // Accept and new commit on the same edge swap the held write.
    clear_mon();
    wr_ready = 1'b0;
    bus_cycle(1'b0, 1'b0, 8'h14, 8'hAA, -1);
    bus_cycle(1'b0, 1'b0, 8'h15, 8'h55, 2);
    check("swap_first_acc", 32'(acc_cnt), 32'h1);
    check("swap_first_payload", 32'(acc_q[0]), 32'({4'h4, 8'hAA}));
    check("swap_next_offered", 32'({wr_valid, wr_addr, wr_data}), 32'({1'b1, 4'h5, 8'h55}));
    check("swap_no_overrun", 32'(overrun), 32'h0);
    wr_ready = 1'b1;
    repeat (2) tick();
    check("swap_second_acc", 32'(acc_cnt), 32'h2);
    check("swap_second_payload", 32'(acc_q[1]), 32'({4'h5, 8'h55}));

    // Reset released while PHI2 is high on a write cycle commits nothing.
    clear_mon();
    reset_b = 1'b0;
    clock_sys = 1'b1; cs = 1'b0; rw = 1'b0; addr = 8'h11; data_in = 8'h77;
    repeat (2) tick();
    reset_b = 1'b1;
    repeat (6) tick();
    clock_sys = 1'b0; cs = 1'b1; rw = 1'b1;
    repeat (8) tick();
    check("midhigh_no_write", 32'(acc_cnt + first_wr + 1), 32'h0);
    check("midhigh_no_strobe", 32'(rd_cnt), 32'h0);

    // Asynchronous reset discards a pending write immediately.
    clear_mon();
    wr_ready = 1'b0;
    bus_cycle(1'b0, 1'b0, 8'h16, 8'h33, -1);
    check("arst_pending", 32'(wr_valid), 32'h1);
    #2 reset_b = 1'b0;
    #1 check("arst_drop", 32'({wr_valid, wr_data}), 32'h0);
    tick();
    reset_b = 1'b1;
    wr_ready = 1'b1;
    repeat (6) tick();
    check("arst_not_delivered", 32'(acc_cnt), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
